// File: rtl/codebook_prefix_engine.sv
// codebook_prefix_engine
// Keeps one active prefix and one symbol count for each low-entropy code
// channel. Each accepted symbol is appended to its channel's prefix, and the
// result is offered to the external codebook lookup. A hit emits a codeword
// and empties that channel. A flush walks every channel in order and emits a
// flush codeword for each channel that still holds symbols.
//
// Optional feature macro: CB_ERR_EN
//   defined   -> overflow, out-of-range index and an unmatched flush entry
//                set err_o; err_o stays set until reset.
//   undefined -> err_o is tied low; the datapath behaves the same.
//
// Handshakes (valid/ready): a transfer happens on a rising clock edge where
// valid and ready are both high. A producer holds valid and payload stable
// until that transfer. ready may depend on the same-cycle state of the
// consumer. m_* payload is registered and does not change while
// m_valid_o & !m_ready_i.
module codebook_prefix_engine #(
  parameter int NUM_CODES = 16,
  parameter int SYM_W     = 4,
  parameter int AP_W      = 64,
  parameter int CNT_W     = 6,
  parameter int ENC_W     = 21,
  parameter int LEN_W     = 6,
  localparam int IDX_W    = $clog2(NUM_CODES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [SYM_W-1:0]  s_sym_i,
  input  logic [IDX_W-1:0]  s_code_i,
  input  logic              flush_i,
  output logic              flush_busy_o,
  output logic [IDX_W-1:0]  lk_code_o,
  output logic [CNT_W-1:0]  lk_cnt_o,
  output logic [AP_W-1:0]   lk_data_o,
  output logic              lk_flush_o,
  input  logic              lk_match_i,
  input  logic [LEN_W-1:0]  lk_length_i,
  input  logic [ENC_W-1:0]  lk_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [LEN_W-1:0]  m_length_o,
  output logic [ENC_W-1:0]  m_data_o,
  output logic [IDX_W-1:0]  m_code_o,
  output logic              err_o,
  output logic              dbg_state_o
);

  localparam int DEPTH = AP_W / SYM_W;
  localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CODES - 1);
  localparam logic [IDX_W:0]   NUM_CODES_X = (IDX_W + 1)'(NUM_CODES);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [AP_W-1:0]  prefix_q [NUM_CODES];
  logic [CNT_W-1:0] cnt_q    [NUM_CODES];

  logic             m_valid_q;
  logic [LEN_W-1:0] m_length_q;
  logic [ENC_W-1:0] m_data_q;
  logic [IDX_W-1:0] m_code_q;

  logic             code_ok;
  logic [IDX_W-1:0] run_idx;
  logic             slot_free;
  logic             accept;
  logic             advance;
  logic             load_out;
  logic             err_event;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [AP_W-1:0]  wr_prefix;
  logic [CNT_W-1:0] wr_cnt;

  // Next state, lookup presentation and storage/output write decisions.
  always_comb begin
    code_ok    = ({1'b0, s_code_i} < NUM_CODES_X);
    // An out-of-range index is dropped, so its lookup view uses channel 0
    // to keep every array read in bounds.
    run_idx    = code_ok ? s_code_i : '0;
    slot_free  = !m_valid_q || m_ready_i;
    state_d    = state_q;
    ptr_d      = ptr_q;
    s_ready_o  = 1'b0;
    accept     = 1'b0;
    advance    = 1'b0;
    load_out   = 1'b0;
    err_event  = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = run_idx;
    wr_prefix  = '0;
    wr_cnt     = '0;
    lk_code_o  = '0;
    lk_cnt_o   = '0;
    lk_data_o  = '0;
    lk_flush_o = 1'b0;
    case (state_q)
      ST_RUN: begin
        s_ready_o = slot_free;
        accept    = s_valid_i && slot_free;
        lk_code_o = s_code_i;
        lk_data_o = {prefix_q[run_idx][AP_W-SYM_W-1:0], s_sym_i};
        lk_cnt_o  = cnt_q[run_idx] + CNT_W'(1);
        if (accept) begin
          if (!code_ok) begin
            err_event = 1'b1;
          end else if (lk_match_i) begin
            // The channel is cleared: wr_prefix/wr_cnt keep their zero defaults.
            load_out = 1'b1;
            wr_en    = 1'b1;
          end else if (lk_cnt_o == DEPTH_CNT) begin
            wr_en     = 1'b1;
            err_event = 1'b1;
          end else begin
            wr_en     = 1'b1;
            wr_prefix = lk_data_o;
            wr_cnt    = lk_cnt_o;
          end
        end
        // Any symbol accepted in this same cycle is stored before the walk begins.
        if (flush_i) begin
          state_d = ST_FLUSH;
          ptr_d   = '0;
        end
      end
      ST_FLUSH: begin
        lk_code_o  = ptr_q;
        lk_data_o  = prefix_q[ptr_q];
        lk_cnt_o   = cnt_q[ptr_q];
        lk_flush_o = 1'b1;
        wr_idx     = ptr_q;
        if (cnt_q[ptr_q] == '0) begin
          advance = 1'b1;
        end else if (slot_free) begin
          load_out  = 1'b1;
          wr_en     = 1'b1;
          err_event = !lk_match_i;
          advance   = 1'b1;
        end
        if (advance) begin
          if (ptr_q == LAST_IDX) begin
            state_d = ST_RUN;
          end else begin
            ptr_d = ptr_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM state and flush walk pointer.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Per-channel prefix and count storage; at most one channel written per cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NUM_CODES; i++) begin
        prefix_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else if (wr_en) begin
      prefix_q[wr_idx] <= wr_prefix;
      cnt_q[wr_idx]    <= wr_cnt;
    end
  end

  // Codeword output register: a new load takes priority over draining.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_valid_q  <= 1'b0;
      m_length_q <= '0;
      m_data_q   <= '0;
      m_code_q   <= '0;
    end else if (load_out) begin
      m_valid_q  <= 1'b1;
      m_length_q <= lk_length_i;
      m_data_q   <= lk_data_i;
      m_code_q   <= lk_code_o;
    end else if (m_ready_i) begin
      m_valid_q  <= 1'b0;
    end
  end

`ifdef CB_ERR_EN
  logic err_q;

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_q <= 1'b0;
    end else if (err_event) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  // Error events are still decoded so both builds share one datapath.
  assign err_o = err_event & 1'b0;
`endif

  assign m_valid_o    = m_valid_q;
  assign m_length_o   = m_length_q;
  assign m_data_o     = m_data_q;
  assign m_code_o     = m_code_q;
  assign flush_busy_o = (state_q == ST_FLUSH);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_codebook_prefix_engine.sv
// Testbench for codebook_prefix_engine.
// The bench drives the lookup port from a small codebook function. A
// reference model, built from per-channel arrays and an expected-codeword
// queue, predicts every output cycle by cycle.
`timescale 1ns/1ps
module tb_codebook_prefix_engine;

  localparam int NUM_CODES = 16;
  localparam int SYM_W     = 4;
  localparam int AP_W      = 64;
  localparam int CNT_W     = 6;
  localparam int ENC_W     = 21;
  localparam int LEN_W     = 6;
  localparam int IDX_W     = 4;
  localparam int DEPTH     = AP_W / SYM_W;
  localparam int OW        = IDX_W + LEN_W + ENC_W;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic              s_valid_i, s_ready_o, flush_i, flush_busy_o;
  logic [SYM_W-1:0]  s_sym_i;
  logic [IDX_W-1:0]  s_code_i, lk_code_o, m_code_o;
  logic [CNT_W-1:0]  lk_cnt_o;
  logic [AP_W-1:0]   lk_data_o;
  logic              lk_flush_o, lk_match_i, m_valid_o, m_ready_i, err_o, dbg_state_o;
  logic [LEN_W-1:0]  lk_length_i, m_length_o;
  logic [ENC_W-1:0]  lk_data_i, m_data_o;

  codebook_prefix_engine dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_sym_i(s_sym_i), .s_code_i(s_code_i),
    .flush_i(flush_i), .flush_busy_o(flush_busy_o),
    .lk_code_o(lk_code_o), .lk_cnt_o(lk_cnt_o), .lk_data_o(lk_data_o), .lk_flush_o(lk_flush_o),
    .lk_match_i(lk_match_i), .lk_length_i(lk_length_i), .lk_data_i(lk_data_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_length_o(m_length_o),
    .m_data_o(m_data_o), .m_code_o(m_code_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- external codebook ----------------
  logic cb_rich = 1'b0;

  function automatic logic [LEN_W+ENC_W:0] cb_fn(input logic [IDX_W-1:0] code,
                                                 input logic [CNT_W-1:0] cnt,
                                                 input logic [AP_W-1:0] data,
                                                 input logic fl, input logic rich);
    logic m;
    logic [LEN_W-1:0] l;
    logic [ENC_W-1:0] d;
    m = 1'b0; l = '0; d = '0;
    if (fl) begin
      m = (code != 4'd9);
      l = cnt + 6'd8;
      d = data[ENC_W-1:0] ^ {code, 17'h0};
    end else if (cnt == 6'd2 && data == 64'h12) begin
      m = 1'b1; l = 6'd5; d = 21'h15;
    end else if (rich && cnt == 6'd3 && data[1:0] == code[1:0]) begin
      m = 1'b1; l = 6'd12; d = {code, data[16:0]};
    end
    return {m, l, d};
  endfunction

  always_comb {lk_match_i, lk_length_i, lk_data_i} = cb_fn(lk_code_o, lk_cnt_o, lk_data_o, lk_flush_o, cb_rich);

  // ---------------- scoreboard / model ----------------
  logic [AP_W-1:0] mdl_prefix [NUM_CODES];
  int              mdl_cnt    [NUM_CODES];
  bit              mdl_flushing;
  int              mdl_ptr;
  bit              mdl_err;
  logic [OW-1:0]   exp_q[$];
  logic [IDX_W-1:0] obs_codes[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < NUM_CODES; i++) begin
      mdl_prefix[i] = '0;
      mdl_cnt[i]    = 0;
    end
    mdl_flushing = 0;
    mdl_ptr      = 0;
    mdl_err      = 0;
    exp_q.delete();
  endtask

  // One clock: compare at the falling edge, advance the model, leave at posedge+1.
  task automatic cycle();
    int c;
    logic e_ready, e_flush, mt, free, adv, e_err;
    logic [IDX_W-1:0] e_code;
    logic [CNT_W-1:0] e_cnt;
    logic [AP_W-1:0]  e_data;
    logic [LEN_W-1:0] ln;
    logic [ENC_W-1:0] dt;
    @(negedge clk_i);
    free = (exp_q.size() == 0) || m_ready_i;
    if (!mdl_flushing) begin
      c = int'(s_code_i);
      e_ready = free;
      e_code  = s_code_i;
      e_data  = {mdl_prefix[c][AP_W-SYM_W-1:0], s_sym_i};
      e_cnt   = CNT_W'(mdl_cnt[c] + 1);
      e_flush = 1'b0;
    end else begin
      c = mdl_ptr;
      e_ready = 1'b0;
      e_code  = IDX_W'(c);
      e_data  = mdl_prefix[c];
      e_cnt   = CNT_W'(mdl_cnt[c]);
      e_flush = 1'b1;
    end
`ifdef CB_ERR_EN
    e_err = mdl_err;
`else
    e_err = 1'b0;
`endif
    check_eq("s_ready", s_ready_o, e_ready);
    check_eq("flush_busy", flush_busy_o, mdl_flushing);
    check_eq("m_valid", m_valid_o, exp_q.size() != 0);
    if (exp_q.size() != 0) check_eq("m_word", {m_code_o, m_length_o, m_data_o}, exp_q[0]);
    check_eq("err", err_o, e_err);
    check_eq("lk_flush", lk_flush_o, e_flush);
    check_eq("lk_code", lk_code_o, e_code);
    check_eq("lk_cnt", lk_cnt_o, e_cnt);
    check_eq("lk_data", lk_data_o, e_data);
    {mt, ln, dt} = cb_fn(e_code, e_cnt, e_data, e_flush, cb_rich);
    if (m_valid_o && m_ready_i) obs_codes.push_back(m_code_o);
    if (exp_q.size() != 0 && m_ready_i) void'(exp_q.pop_front());
    if (!mdl_flushing) begin
      if (s_valid_i && free) begin
        if (mt) begin
          exp_q.push_back({e_code, ln, dt});
          mdl_prefix[c] = '0; mdl_cnt[c] = 0;
        end else if (mdl_cnt[c] + 1 == DEPTH) begin
          mdl_prefix[c] = '0; mdl_cnt[c] = 0; mdl_err = 1;
        end else begin
          mdl_prefix[c] = e_data; mdl_cnt[c] = mdl_cnt[c] + 1;
        end
      end
      if (flush_i) begin mdl_flushing = 1; mdl_ptr = 0; end
    end else begin
      adv = 1'b0;
      if (mdl_cnt[c] == 0) adv = 1'b1;
      else if (free) begin
        exp_q.push_back({e_code, ln, dt});
        mdl_prefix[c] = '0; mdl_cnt[c] = 0;
        if (!mt) mdl_err = 1;
        adv = 1'b1;
      end
      if (adv) begin
        if (mdl_ptr == NUM_CODES - 1) mdl_flushing = 0;
        else mdl_ptr++;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [SYM_W-1:0] sym, input logic [IDX_W-1:0] code,
                       input logic fl, input logic rdy);
    s_valid_i = v; s_sym_i = sym; s_code_i = code; flush_i = fl; m_ready_i = rdy;
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt;
    logic [CNT_W-1:0] cap_cnt;
    logic [AP_W-1:0]  cap_data;
    s_valid_i = 0; s_sym_i = 0; s_code_i = 0; flush_i = 0; m_ready_i = 1;
    mdl_reset();
    #2 rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_m_valid", m_valid_o, 0);
    check_eq("rst_s_ready", s_ready_o, 1);
    check_eq("rst_busy", flush_busy_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_payload", {m_code_o, m_length_o, m_data_o}, 0);
    check_eq("rst_state", dbg_state_o, 0);
    rst_i = 1'b1;

    // Match path: symbols 1,2 on code 3 hit the codebook entry.
    drive(1, 4'd1, 4'd4, 0, 1);
    drive(1, 4'd1, 4'd3, 0, 1);
    drive(1, 4'd2, 4'd3, 0, 0);
    check_eq("match_valid", m_valid_o, 1);
    check_eq("match_len", m_length_o, 5);
    check_eq("match_data", m_data_o, 21'h15);
    check_eq("match_code", m_code_o, 3);

    // Backpressure for 10 cycles, then release with a symbol waiting.
    s_valid_i = 1; s_sym_i = 4'd2; s_code_i = 4'd4; m_ready_i = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check_eq("bp_ready", s_ready_o, 0);
      check_eq("bp_hold", {m_code_o, m_length_o, m_data_o}, {4'd3, 6'd5, 21'h15});
    end
    drive(1, 4'd2, 4'd4, 0, 1);
    check_eq("bp_next_code", m_code_o, 4);
    drive(0, 4'd0, 4'd3, 0, 1);
    check_eq("match_cnt_cleared", lk_cnt_o, 1);

    // Flush ordering: code 0 holds one symbol, code 15 holds two.
    drive(1, 4'd3, 4'd0, 0, 1);
    drive(1, 4'd1, 4'd15, 0, 1);
    drive(1, 4'd3, 4'd15, 0, 1);
    obs_codes.delete();
    drive(0, 4'd0, 4'd0, 1, 1);
    flush_i = 0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (flush_busy_o) busy_cnt++;
      cycle();
    end
    check_eq("flush_count", obs_codes.size(), 2);
    if (obs_codes.size() == 2) begin
      check_eq("flush_first", obs_codes[0], 0);
      check_eq("flush_second", obs_codes[1], 15);
    end
    check_eq("flush_busy_len", busy_cnt, 16);
    s_code_i = 4'd15; #1;
    check_eq("flush_cleared15", lk_cnt_o, 1);

    // Flush coincident with an accept on empty code 5.
    obs_codes.delete();
    cap_cnt = '0; cap_data = '0;
    drive(1, 4'd7, 4'd5, 1, 1);
    s_valid_i = 0; flush_i = 0;
    for (int i = 0; i < 40; i++) begin
      if (lk_flush_o && lk_code_o == 4'd5) begin cap_cnt = lk_cnt_o; cap_data = lk_data_o; end
      cycle();
    end
    check_eq("coinc_cnt", cap_cnt, 1);
    check_eq("coinc_data", cap_data, 64'h7);
    check_eq("coinc_count", obs_codes.size(), 1);

    // Overflow: DEPTH unmatched symbols on code 7.
    obs_codes.delete();
    for (int i = 0; i < DEPTH; i++) drive(1, SYM_W'($urandom_range(3, 15)), 4'd7, 0, 1);
    s_valid_i = 0; #1;
    check_eq("ovf_no_out", m_valid_o, 0);
    check_eq("ovf_cnt", lk_cnt_o, 1);
`ifdef CB_ERR_EN
    check_eq("ovf_err", err_o, 1);
`else
    check_eq("ovf_err", err_o, 0);
`endif
    check_eq("ovf_emitted", obs_codes.size(), 0);

    // Randomized traffic with a richer codebook.
    cb_rich = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, SYM_W'($urandom_range(0, 15)), IDX_W'($urandom_range(0, 15)),
            $urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7);
    end
    for (int i = 0; i < 64 && (mdl_flushing || exp_q.size() != 0); i++) drive(0, 0, 0, 0, 1);
    check_eq("drain_busy", flush_busy_o, 0);
    check_eq("drain_valid", m_valid_o, 0);

    // Reset in the middle of a flush.
    drive(1, 4'd5, 4'd2, 0, 1);
    drive(0, 4'd0, 4'd0, 1, 1);
    drive(0, 4'd0, 4'd0, 0, 1);
    check_eq("mid_busy", flush_busy_o, 1);
    #2 rst_i = 1'b0;
    #1;
    mdl_reset();
    check_eq("mid_rst_valid", m_valid_o, 0);
    check_eq("mid_rst_busy", flush_busy_o, 0);
    check_eq("mid_rst_ready", s_ready_o, 1);
    check_eq("mid_rst_err", err_o, 0);
    check_eq("mid_rst_payload", {m_code_o, m_length_o, m_data_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_eq("post_rst_state", dbg_state_o, 0);
    s_code_i = 4'd2; #1;
    check_eq("post_rst_cnt", lk_cnt_o, 1);
    for (int i = 0; i < 20; i++) drive($urandom_range(0, 1), SYM_W'($urandom_range(0, 15)),
                                       IDX_W'($urandom_range(0, 15)), 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
